// File: rtl/div_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
// The master side issues operands and rd; the slave side returns result, rd and status.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            abort_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_wr_addr_i;
  logic [XLEN-1:0] result_o;
  logic            ready_o;
  logic            busy_o;
  logic [4:0]      reg_wr_addr_o;

  modport master (
    output start_i, abort_i, op_i, dividend_i, divisor_i, reg_wr_addr_i,
    input  result_o, ready_o, busy_o, reg_wr_addr_o
  );

  modport slave (
    input  start_i, abort_i, op_i, dividend_i, divisor_i, reg_wr_addr_i,
    output result_o, ready_o, busy_o, reg_wr_addr_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_RESULT_CACHE_EN: reuse the last computed result for matching operands.
module div_unit #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start_i; operands latched on accept
  // START | strip signs, detect divide-by-zero / overflow / cache hit
  // CALC  | one shift-subtract step per cycle, XLEN steps
  // END   | result_o valid, ready_o pulses
  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] dvd_q, dvs_q, quo_q, rem_q, dmag_q, result_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q, rd_out_q;
  logic            neg_quo_q, neg_rem_q;
  logic [CW-1:0]   cnt_q;

  logic            sgn, special, hit, load_res, busy, ready;
  logic [XLEN-1:0] spec_quo, spec_rem, hit_quo, hit_rem, start_res, res_d;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic [XLEN-1:0] quo_step, rem_step, fin_quo, fin_rem;

  assign sgn = ~op_q[0];

  always_comb begin
    special  = 1'b0;
    spec_quo = '0;
    spec_rem = '0;
    if (dvs_q == '0) begin
      special  = 1'b1;
      spec_quo = '1;
      spec_rem = dvd_q;
    end else if (sgn && (dvd_q == MIN_NEG) && (dvs_q == '1)) begin
      special  = 1'b1;
      spec_quo = MIN_NEG;
      spec_rem = '0;
    end
  end

  // Borrow out of the XLEN+1-bit trial subtract decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dmag_q};
    if (!rem_diff[XLEN]) begin
      rem_step = rem_diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end
    fin_quo = neg_quo_q ? -quo_step : quo_step;
    fin_rem = neg_rem_q ? -rem_step : rem_step;
  end

`ifdef DIV_RESULT_CACHE_EN
  logic [XLEN-1:0] c_dvd_q, c_dvs_q, c_quo_q, c_rem_q;
  logic            c_sgn_q, c_valid_q;

  assign hit     = c_valid_q && (c_dvd_q == dvd_q) && (c_dvs_q == dvs_q) && (c_sgn_q == sgn);
  assign hit_quo = c_quo_q;
  assign hit_rem = c_rem_q;

  // Only a CALC that actually reaches END refreshes the entry; aborts never do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_dvd_q   <= '0;
      c_dvs_q   <= '0;
      c_quo_q   <= '0;
      c_rem_q   <= '0;
      c_sgn_q   <= 1'b0;
      c_valid_q <= 1'b0;
    end else if ((state_q == S_CALC) && (state_d == S_END)) begin
      c_dvd_q   <= dvd_q;
      c_dvs_q   <= dvs_q;
      c_quo_q   <= fin_quo;
      c_rem_q   <= fin_rem;
      c_sgn_q   <= sgn;
      c_valid_q <= 1'b1;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_quo = '0;
  assign hit_rem = '0;
`endif

  assign start_res = op_q[1] ? (special ? spec_rem : hit_rem)
                             : (special ? spec_quo : hit_quo);
  assign res_d     = (state_q == S_START) ? start_res : (op_q[1] ? fin_rem : fin_quo);
  assign load_res  = (state_d == S_END) && (state_q != S_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i && !bus.abort_i) state_d = S_START;
      S_START: begin
        if (bus.abort_i)          state_d = S_IDLE;
        else if (special || hit)  state_d = S_END;
        else                      state_d = S_CALC;
      end
      S_CALC: begin
        if (bus.abort_i)          state_d = S_IDLE;
        else if (cnt_q == LAST)   state_d = S_END;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (state_q)
      S_IDLE:          busy  = bus.start_i && !bus.abort_i;
      S_START, S_CALC: busy  = 1'b1;
      S_END:           ready = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dmag_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            dvd_q <= bus.dividend_i;
            dvs_q <= bus.divisor_i;
            op_q  <= bus.op_i[1:0];
            rd_q  <= bus.reg_wr_addr_i;
          end
        end
        S_START: begin
          quo_q     <= (sgn && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
          dmag_q    <= (sgn && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_quo_q <= sgn && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
          neg_rem_q <= sgn && dvd_q[XLEN-1];
        end
        S_CALC: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
      if (load_res) begin
        result_q <= res_d;
        rd_out_q <= rd_q;
      end
    end
  end

  assign bus.result_o      = result_q;
  assign bus.reg_wr_addr_o = rd_out_q;
  assign bus.ready_o       = ready;
  assign bus.busy_o        = busy;
endmodule
